demux1xn_bp: RTL and testbench



---
 rtl/demux1xn_bp_if.sv | 28 ++
 rtl/demux1xn_bp.sv | 135 +++++++++++++
 tb/tb_demux1xn_bp.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/demux1xn_bp_if.sv
// Stream bus of the 1xN demux: upstream word/handshake, per-channel full flags,
// and the flattened channel outputs with their one-hot push strobes.
interface demux1xn_bp_if #(
  parameter int DATA_W  = 8,
  parameter int NUM_OUT = 4,
  parameter int SEL_W   = 2
);
  logic [DATA_W-1:0]         in;
  logic                      valid_in;
  logic [SEL_W-1:0]          classif;
  logic [NUM_OUT-1:0]        fifo_full;
  logic                      ready_out;
  logic [NUM_OUT-1:0]        push;
  logic [NUM_OUT*DATA_W-1:0] out;
  logic                      err_class;

  // Environment side: feeds words and full flags, observes the channels
  modport master (
    output in, valid_in, classif, fifo_full,
    input  ready_out, push, out, err_class
  );

  // Demux side
  modport slave (
    input  in, valid_in, classif, fifo_full,
    output ready_out, push, out, err_class
  );
endinterface

// File: rtl/demux1xn_bp.sv
// 1xN stream demux with valid/ready input, per-channel full backpressure via a
// one-entry hold register, and out-of-range class detection. DEMUX1XN_STATS_EN adds counters.
module demux1xn_bp #(
  parameter int DATA_W  = 8,
  parameter int NUM_OUT = 4,
  parameter int SEL_W   = 2   // 2**SEL_W must cover NUM_OUT
) (
  input  logic                  clk,
  input  logic                  reset,
  demux1xn_bp_if.slave          bus
`ifdef DEMUX1XN_STATS_EN
  ,
  output logic [NUM_OUT*16-1:0] word_cnt,
  output logic [15:0]           drop_cnt
`endif
);

  typedef enum logic {PASS, HOLD} state_t;

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   hold_data_reg, hold_data_next;
  logic [SEL_W-1:0]    hold_c_reg, hold_c_next;
  logic [NUM_OUT-1:0]  push_reg, push_next;
  logic                err_reg, err_next;
  logic                write_en;
  logic [SEL_W-1:0]    write_ch;
  logic [DATA_W-1:0]   write_data;
  logic [DATA_W-1:0]   out_reg [NUM_OUT];
  logic                accept;
  logic                in_range;

  assign bus.ready_out = reset & (state_reg == PASS);
  assign accept        = bus.valid_in & bus.ready_out;
  assign in_range      = (32'(bus.classif) < 32'(NUM_OUT));

  always_comb begin
    state_next     = state_reg;
    hold_data_next = hold_data_reg;
    hold_c_next    = hold_c_reg;
    err_next       = 1'b0;
    write_en       = 1'b0;
    write_ch       = bus.classif;
    write_data     = bus.in;
    case (state_reg)
      PASS: begin
        if (accept) begin
          if (!in_range) begin
            err_next = 1'b1;
          end else if (bus.fifo_full[bus.classif]) begin
            hold_data_next = bus.in;
            hold_c_next    = bus.classif;
            state_next     = HOLD;
          end else begin
            write_en = 1'b1;
          end
        end
      end
      HOLD: begin
        // The held word retries every cycle until its channel has room
        write_ch   = hold_c_reg;
        write_data = hold_data_reg;
        if (!bus.fifo_full[hold_c_reg]) begin
          write_en   = 1'b1;
          state_next = PASS;
        end
      end
      default: state_next = PASS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= PASS;
      hold_data_reg <= '0;
      hold_c_reg    <= '0;
      push_reg      <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      hold_data_reg <= hold_data_next;
      hold_c_reg    <= hold_c_next;
      push_reg      <= push_next;
      err_reg       <= err_next;
    end
  end

  assign bus.push      = push_reg;
  assign bus.err_class = err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUT; gi++) begin : g_ch
      assign push_next[gi] = write_en && (write_ch == SEL_W'(gi));

      always_ff @(posedge clk) begin
        if (!reset) begin
          out_reg[gi] <= '0;
        end else if (push_next[gi]) begin
          out_reg[gi] <= write_data;
        end
      end

      assign bus.out[gi*DATA_W +: DATA_W] = out_reg[gi];

`ifdef DEMUX1XN_STATS_EN
      logic [15:0] word_cnt_reg;

      always_ff @(posedge clk) begin
        if (!reset) begin
          word_cnt_reg <= '0;
        end else if (push_next[gi] && (word_cnt_reg != 16'hFFFF)) begin
          word_cnt_reg <= word_cnt_reg + 16'd1;
        end
      end

      assign word_cnt[gi*16 +: 16] = word_cnt_reg;
`endif
    end
  endgenerate

`ifdef DEMUX1XN_STATS_EN
  logic [15:0] drop_cnt_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_cnt_reg <= '0;
    end else if (err_next && (drop_cnt_reg != 16'hFFFF)) begin
      drop_cnt_reg <= drop_cnt_reg + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_demux1xn_bp.sv
// Scoreboard bench for demux1xn_bp: directed scenarios then random traffic, checked
// against a queue-based reference model. Build with DEMUX1XN_STATS_EN to cover the counters.
module tb_demux1xn_bp;
  localparam int DATA_W  = 8;
  localparam int NUM_OUT = 5;
  localparam int SEL_W   = 3;

  logic clk = 1'b0;
  logic reset;

  demux1xn_bp_if #(.DATA_W(DATA_W), .NUM_OUT(NUM_OUT), .SEL_W(SEL_W)) bus ();

`ifdef DEMUX1XN_STATS_EN
  logic [NUM_OUT*16-1:0] word_cnt;
  logic [15:0]           drop_cnt;
`endif

  demux1xn_bp #(.DATA_W(DATA_W), .NUM_OUT(NUM_OUT), .SEL_W(SEL_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus)
`ifdef DEMUX1XN_STATS_EN
    ,
    .word_cnt (word_cnt),
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SEL_W-1:0]  c;
    logic [DATA_W-1:0] d;
  } word_t;

  typedef struct {
    logic [NUM_OUT-1:0]        push;
    logic                      err;
    logic [NUM_OUT*DATA_W-1:0] out;
    bit                        pend_empty;
    logic [NUM_OUT*16-1:0]     wc;
    logic [15:0]               dc;
  } exp_t;

  word_t             pend_q[$];
  exp_t              exp_q[$];
  logic [DATA_W-1:0] out_m [NUM_OUT];
  int unsigned       wc_m  [NUM_OUT];
  int unsigned       dc_m;
  int                tests_run = 0;
  int                fails     = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    tests_run++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Reference model: a word is either delivered, dropped, or parked in a pending queue
  task automatic model_step();
    exp_t               e;
    word_t              w;
    logic [NUM_OUT-1:0] p;
    logic               er;
    p  = '0;
    er = 1'b0;
    if (reset !== 1'b1) begin
      pend_q.delete();
      for (int i = 0; i < NUM_OUT; i++) begin
        out_m[i] = '0;
        wc_m[i]  = 0;
      end
      dc_m = 0;
    end else if (pend_q.size() > 0) begin
      w = pend_q[0];
      if (!bus.fifo_full[w.c]) begin
        out_m[w.c] = w.d;
        p[w.c]     = 1'b1;
        void'(pend_q.pop_front());
      end
    end else if (bus.valid_in) begin
      if (int'(bus.classif) >= NUM_OUT) begin
        er = 1'b1;
      end else if (bus.fifo_full[bus.classif]) begin
        w.c = bus.classif;
        w.d = bus.in;
        pend_q.push_back(w);
      end else begin
        out_m[bus.classif] = bus.in;
        p[bus.classif]     = 1'b1;
      end
    end
    for (int i = 0; i < NUM_OUT; i++) begin
      if (p[i] && wc_m[i] < 65535) wc_m[i]++;
      e.out[i*DATA_W +: DATA_W] = out_m[i];
      e.wc[i*16 +: 16]          = 16'(wc_m[i]);
    end
    if (er && dc_m < 65535) dc_m++;
    e.push       = p;
    e.err        = er;
    e.pend_empty = (pend_q.size() == 0);
    e.dc         = 16'(dc_m);
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: one expectation per clock edge, compared mid-cycle
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("push",      128'(bus.push),      128'(e.push));
      check("err_class", 128'(bus.err_class), 128'(e.err));
      check("out",       128'(bus.out),       128'(e.out));
      check("ready_out", 128'(bus.ready_out), 128'(reset && e.pend_empty));
`ifdef DEMUX1XN_STATS_EN
      check("word_cnt",  128'(word_cnt),      128'(e.wc));
      check("drop_cnt",  128'(drop_cnt),      128'(e.dc));
`endif
    end
  end

  task automatic drive(input logic r, input logic v, input logic [SEL_W-1:0] c,
                       input logic [DATA_W-1:0] d, input logic [NUM_OUT-1:0] f);
    reset         = r;
    bus.valid_in  = v;
    bus.classif   = c;
    bus.in        = d;
    bus.fifo_full = f;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [NUM_OUT-1:0] f;
    // Reset with valid asserted
    drive(1'b0, 1'b1, 3'd0, 8'hFF, 5'b00000);
    drive(1'b0, 1'b1, 3'd1, 8'hEE, 5'b00000);
    // Routing to every channel back-to-back
    drive(1'b1, 1'b1, 3'd0, 8'hA1, 5'b00000);
    drive(1'b1, 1'b1, 3'd1, 8'hB2, 5'b00000);
    drive(1'b1, 1'b1, 3'd2, 8'hC3, 5'b00000);
    drive(1'b1, 1'b1, 3'd3, 8'hD4, 5'b00000);
    drive(1'b1, 1'b1, 3'd4, 8'hE5, 5'b00000);
    drive(1'b1, 1'b0, 3'd0, 8'h00, 5'b00000);
    // Backpressure on channel 2 while a new word waits on the input
    drive(1'b1, 1'b1, 3'd2, 8'h5A, 5'b00100);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 3'd0, 8'h11, 5'b00100);
    drive(1'b1, 1'b1, 3'd0, 8'h11, 5'b00000);
    drive(1'b1, 1'b1, 3'd0, 8'h11, 5'b00000);
    drive(1'b1, 1'b0, 3'd0, 8'h00, 5'b00000);
    // Out-of-range classes
    drive(1'b1, 1'b1, 3'd5, 8'hEE, 5'b00000);
    drive(1'b1, 1'b1, 3'd7, 8'hEF, 5'b00000);
    drive(1'b1, 1'b0, 3'd0, 8'h00, 5'b00000);
    // Reset while holding
    drive(1'b1, 1'b1, 3'd1, 8'h77, 5'b00010);
    drive(1'b1, 1'b0, 3'd0, 8'h00, 5'b00010);
    drive(1'b0, 1'b0, 3'd0, 8'h00, 5'b00010);
    drive(1'b1, 1'b0, 3'd0, 8'h00, 5'b00000);
    drive(1'b1, 1'b0, 3'd0, 8'h00, 5'b00000);
    // Random traffic
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < NUM_OUT; b++) f[b] = ($urandom_range(3) == 0);
      drive($urandom_range(63) != 0, $urandom_range(3) != 0,
            SEL_W'($urandom_range(7)), DATA_W'($urandom), f);
    end
`ifdef DEMUX1XN_STATS_EN
    // Counter saturation on channel 0
    drive(1'b0, 1'b0, 3'd0, 8'h00, 5'b00000);
    for (int n = 0; n < 65540; n++) drive(1'b1, 1'b1, 3'd0, DATA_W'(n), 5'b00000);
`endif
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 3'd0, 8'h00, 5'b00000);
    @(negedge clk);
    #1;
    check("drain", 128'(exp_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
